pe_acc_quant: RTL and testbench

- Downstream consumer of the PE adder stage: takes the DATA_COPIES-lane vector of sign-extended 2*DATA_WIDTH sums and accumulates it over a programmed number of beats.
- After the last beat, requantizes each lane to DATA_WIDTH with a programmable rounding right-shift and saturation.
- Presents the result on a valid/ready output port for the write-back path.

---
 rtl/pe_acc_quant.sv | 165 ++++++++++++++++
 tb/tb_pe_acc_quant.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_quant.sv
// Per-lane accumulator with rounding/saturating requantizer, driven by a small
// IDLE/ACC/QUANT/OUT controller that feeds the write-back valid/ready port.
module pe_acc_quant_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clr,
    input  logic                      i_acc_en,
    input  logic                      i_q_en,
    input  logic [4:0]                i_shift,
    input  logic [2*DATA_WIDTH-1:0]   i_lane,
    output logic [DATA_WIDTH-1:0]     o_q
);
    localparam int IW = 2*DATA_WIDTH;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [ACC_WIDTH:0]   w_half;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH:0]   w_shr;
    logic                        w_sat_hi;
    logic                        w_sat_lo;
    logic        [DATA_WIDTH-1:0] w_q;

    // Rounding add is one bit wider than the accumulator so it cannot wrap.
    assign w_half = (i_shift == 5'd0) ? '0
                  : ({{ACC_WIDTH{1'b0}}, 1'b1} << (i_shift - 5'd1));
    assign w_sum  = $signed({r_acc[ACC_WIDTH-1], r_acc} + w_half);
    assign w_shr  = w_sum >>> i_shift;

    assign w_sat_hi = !w_shr[ACC_WIDTH] &&  (|w_shr[ACC_WIDTH-1:DATA_WIDTH-1]);
    assign w_sat_lo =  w_shr[ACC_WIDTH] && !(&w_shr[ACC_WIDTH-1:DATA_WIDTH-1]);

    always_comb begin
        w_q = w_shr[DATA_WIDTH-1:0];
        if (w_sat_hi) w_q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (w_sat_lo) w_q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            o_q   <= '0;
        end else begin
            if (i_clr)
                r_acc <= '0;
            else if (i_acc_en)
                r_acc <= r_acc + {{(ACC_WIDTH-IW){i_lane[IW-1]}}, i_lane};
            if (i_q_en)
                o_q <= w_q;
        end
    end
endmodule

module pe_acc_quant #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int CNT_WIDTH   = 8,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [CNT_WIDTH-1:0]                i_acc_len,
    input  logic [4:0]                          i_shift,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_add_result,
    input  logic                                i_add_vld,
    output logic                                o_add_rdy,
    output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_qdata,
    output logic                                o_qdata_vld,
    input  logic                                i_qdata_rdy,
    output logic                                o_busy,
    output logic                                o_done
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_QUANT, S_OUT} state_t;

    state_t               r_state, w_next;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [4:0]           r_shift;
    logic                 r_done;
    logic                 w_clr;
    logic                 w_beat;
    logic                 w_q_en;
    logic                 w_hs;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_add_rdy   = 1'b0;
        o_qdata_vld = 1'b0;
        w_clr       = 1'b0;
        w_beat      = 1'b0;
        w_q_en      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && i_acc_len != '0) begin
                    w_clr  = 1'b1;
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                o_add_rdy = 1'b1;
                w_beat    = i_add_vld;
                if (i_add_vld && r_cnt == r_len - 1'b1)
                    w_next = S_QUANT;
            end
            S_QUANT: begin
                w_q_en = 1'b1;
                w_next = S_OUT;
            end
            S_OUT: begin
                o_qdata_vld = 1'b1;
                if (i_qdata_rdy) begin
                    w_hs   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs;
            if (w_clr) begin
                r_len   <= i_acc_len;
                r_shift <= i_shift;
                r_cnt   <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;

    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
        pe_acc_quant_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_clr    (w_clr),
            .i_acc_en (w_beat),
            .i_q_en   (w_q_en),
            .i_shift  (r_shift),
            .i_lane   (i_add_result[2*DATA_WIDTH*g +: 2*DATA_WIDTH]),
            .o_q      (o_qdata[DATA_WIDTH*g +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_pe_acc_quant.sv
// Scoreboard bench for pe_acc_quant: driver pushes model results, monitor pops on handshake.
module tb_pe_acc_quant;
    localparam int DW = 8;
    localparam int DC = 32;
    localparam int CW = 8;
    localparam int AW = 24;
    localparam int IW = DC*2*DW;
    localparam int OW = DC*DW;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_acc_len = '0;
    logic [4:0]    i_shift = '0;
    logic [IW-1:0] i_add_result = '0;
    logic          i_add_vld = 1'b0;
    logic          o_add_rdy;
    logic [OW-1:0] o_qdata;
    logic          o_qdata_vld;
    logic          i_qdata_rdy = 1'b1;
    logic          o_busy;
    logic          o_done;

    pe_acc_quant #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_acc_len(i_acc_len),
        .i_shift(i_shift), .i_add_result(i_add_result), .i_add_vld(i_add_vld),
        .o_add_rdy(o_add_rdy), .o_qdata(o_qdata), .o_qdata_vld(o_qdata_vld),
        .i_qdata_rdy(i_qdata_rdy), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int            checks = 0;
    int            failures = 0;
    logic [OW-1:0] exp_q[$];
    logic [IW-1:0] beats[256];
    int            force_lo = 0;
    bit            rand_bp = 1'b0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: exact integer sum, round half up via floor division, then clamp.
    function automatic int quant(input longint s, input int sh);
        longint d, r, q;
        if (sh == 0) begin
            q = s;
        end else begin
            d = longint'(1) << sh;
            r = s + d / 2;
            q = r / d;
            if (r < 0 && (r % d) != 0) q = q - 1;
        end
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic logic [OW-1:0] model(input int len, input int sh);
        logic [OW-1:0] out;
        logic [15:0]   v;
        logic [7:0]    b8;
        longint        s;
        int            q;
        out = '0;
        for (int l = 0; l < DC; l++) begin
            s = 0;
            for (int b = 0; b < len; b++) begin
                v = beats[b][l*16 +: 16];
                s = s + longint'($signed(v));
            end
            q  = quant(s, sh);
            b8 = q[7:0];
            out[l*8 +: 8] = b8;
        end
        return out;
    endfunction

    task automatic set_lane(input int b, input int l, input int v);
        beats[b][l*16 +: 16] = 16'(v);
    endtask

    task automatic fill_rand(input int len, input int maxv);
        for (int b = 0; b < len; b++)
            for (int l = 0; l < DC; l++)
                set_lane(b, l, int'($urandom_range(0, 2*maxv)) - maxv);
    endtask

    // Monitor: scoreboard pop on handshake, stability under backpressure, done pulse.
    bit            prev_vld = 1'b0;
    logic [OW-1:0] prev_q = '0;
    bit            exp_done = 1'b0;
    always @(negedge i_clk) begin
        chk1("done_pulse", 32'(o_done), 32'(exp_done));
        exp_done = 1'b0;
        if (o_qdata_vld && prev_vld) chk("qdata_stable", o_qdata, prev_q);
        if (o_qdata_vld && i_qdata_rdy) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL qdata_unexpected actual=%h required=none", o_qdata);
            end else begin
                chk("qdata", o_qdata, exp_q.pop_front());
            end
            exp_done = 1'b1;
        end
        prev_vld = o_qdata_vld;
        prev_q   = o_qdata;
    end

    always @(posedge i_clk) begin
        #1;
        if (force_lo > 0) begin
            i_qdata_rdy = 1'b0;
            if (o_qdata_vld) force_lo--;
        end else begin
            i_qdata_rdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Called at a negedge with the DUT idle; returns at the first idle negedge after.
    task automatic run_job(input int len, input int sh, input int gap, input bit mid_start);
        int guard;
        i_start = 1'b1; i_acc_len = CW'(len); i_shift = 5'(sh);
        @(negedge i_clk);
        i_start = 1'b0; i_acc_len = CW'($urandom); i_shift = 5'($urandom);
        for (int b = 0; b < len; b++) begin
            for (int g = 0; g < gap; g++) begin
                i_add_vld = 1'b0; i_add_result = IW'($urandom);
                @(negedge i_clk);
            end
            i_add_vld = 1'b1; i_add_result = beats[b];
            if (mid_start && b == 1) begin
                i_start = 1'b1; i_acc_len = CW'(len + 3);
            end
            guard = 0;
            while (!o_add_rdy && guard < 100) begin
                @(negedge i_clk); guard++;
            end
            if (!o_add_rdy) begin
                checks++; failures++;
                $display("FAIL beat_timeout actual=%0d required=%0d", b, len);
                i_add_vld = 1'b0;
                return;
            end
            @(negedge i_clk);
            i_start = 1'b0;
        end
        i_add_vld = 1'b0; i_add_result = IW'($urandom);
        chk1("add_rdy_drop", 32'(o_add_rdy), 0);
        chk1("vld_in_quant", 32'(o_qdata_vld), 0);
        exp_q.push_back(model(len, sh));
        @(negedge i_clk);
        chk1("vld_latency", 32'(o_qdata_vld), 1);
        guard = 0;
        while (o_busy && guard < 200) begin
            @(negedge i_clk); guard++;
        end
        if (o_busy) begin
            checks++; failures++;
            $display("FAIL job_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk1("rst_busy", 32'(o_busy), 0);
        chk1("rst_add_rdy", 32'(o_add_rdy), 0);
        chk1("rst_vld", 32'(o_qdata_vld), 0);
        chk("rst_qdata", o_qdata, '0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // single beat, all lanes +100
        beats[0] = {DC{16'd100}};
        run_job(1, 0, 0, 1'b0);

        // accumulate and round half up
        fill_rand(4, 50);
        set_lane(0, 0, 3);  set_lane(1, 0, 3);  set_lane(2, 0, 3);  set_lane(3, 0, 1);
        set_lane(0, 1, -3); set_lane(1, 1, -3); set_lane(2, 1, -3); set_lane(3, 1, -1);
        run_job(4, 2, 0, 1'b0);

        // saturation both directions
        fill_rand(8, 30);
        for (int b = 0; b < 8; b++) begin
            set_lane(b, 0, 200); set_lane(b, 1, -256);
        end
        run_job(8, 0, 0, 1'b0);

        // stalls and backpressure
        fill_rand(3, 1000);
        force_lo = 5;
        run_job(3, 3, 2, 1'b0);

        // start with zero length is ignored
        i_start = 1'b1; i_acc_len = '0; i_shift = 5'd1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("len0_busy", 32'(o_busy), 0);
            chk1("len0_add_rdy", 32'(o_add_rdy), 0);
            @(negedge i_clk);
        end

        // restart while accumulating uses the original length
        fill_rand(4, 500);
        run_job(4, 4, 0, 1'b1);

        // reset in the middle of a job
        fill_rand(2, 500);
        i_start = 1'b1; i_acc_len = CW'(5); i_shift = 5'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_add_vld = 1'b1; i_add_result = beats[b];
            @(negedge i_clk);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0; i_add_vld = 1'b0;
        chk1("midrst_busy", 32'(o_busy), 0);
        chk1("midrst_add_rdy", 32'(o_add_rdy), 0);
        chk1("midrst_vld", 32'(o_qdata_vld), 0);
        chk1("midrst_done", 32'(o_done), 0);
        chk("midrst_qdata", o_qdata, '0);
        beats[0] = {DC{16'd7}};
        run_job(1, 0, 0, 1'b0);

        // randomized jobs with backpressure, back-to-back starts
        rand_bp = 1'b1;
        for (int j = 0; j < 20; j++) begin
            fill_rand(12, 32767);
            run_job($urandom_range(1, 12), $urandom_range(0, AW-1), $urandom_range(0, 2), 1'b0);
        end
        fill_rand(255, 32767);
        run_job(255, 8, 0, 1'b0);
        rand_bp = 1'b0;

        repeat (4) @(negedge i_clk);
        chk1("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
